// File: rtl/qspi_pkg.sv
// Shared types and constants for the QSPI flash responder.
package qspi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_IGNORE
  } qspi_resp_state_t;

  localparam logic [7:0] QSPI_OP_READ_QUAD_OUT = 8'h6B;
  localparam logic [7:0] QSPI_OP_READ_QUAD_IO  = 8'hEB;

  localparam int QSPI_SYNC_STAGES = 2;

endpackage

// File: rtl/qspi_edge_sync.sv
// Two-flop synchronizer for one asynchronous input plus single-clk rise/fall pulses.
module qspi_edge_sync
  import qspi_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [QSPI_SYNC_STAGES-1:0] sync_reg;
  logic                        prev_reg;

  // Reset to low so that a line already held low after reset never looks like a fresh fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[QSPI_SYNC_STAGES-2:0], async_in};
      prev_reg <= sync_reg[QSPI_SYNC_STAGES-1];
    end
  end

  assign level = sync_reg[QSPI_SYNC_STAGES-1];
  assign rise  = level & ~prev_reg;
  assign fall  = ~level & prev_reg;

endmodule

// File: rtl/qspi_flash_responder.sv
// QSPI flash target answering Fast Read Quad Output (0x6B) from a word-wide memory.
// Optional QSPI_RESP_QUAD_IO_EN also accepts Fast Read Quad I/O (0xEB).
module qspi_flash_responder
  import qspi_pkg::*;
#(
  parameter int ADDR_W       = 24,
  parameter int DUMMY_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              csb,
  input  logic [3:0]        io_in,
  output logic [3:0]        io_out,
  output logic              io_oe,
  output logic              mem_req,
  output logic [ADDR_W-3:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  localparam int CNT_W = 8;

  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic csb_level, csb_rise_unused, csb_fall;
  logic [3:0] io_s;

  qspi_edge_sync u_sclk_sync (
    .clk(clk), .rst(rst), .async_in(sclk),
    .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  qspi_edge_sync u_csb_sync (
    .clk(clk), .rst(rst), .async_in(csb),
    .level(csb_level), .rise(csb_rise_unused), .fall(csb_fall)
  );

  for (genvar gi = 0; gi < 4; gi++) begin : g_io_sync
    logic [QSPI_SYNC_STAGES-1:0] sync_reg;
    always_ff @(posedge clk) begin
      if (rst) sync_reg <= '0;
      else     sync_reg <= {sync_reg[QSPI_SYNC_STAGES-2:0], io_in[gi]};
    end
    assign io_s[gi] = sync_reg[QSPI_SYNC_STAGES-1];
  end

  qspi_resp_state_t  state_reg, state_next;
  logic [6:0]        cmd_reg, cmd_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              nib_lo_reg, nib_lo_next;
  logic [3:0]        io_out_reg, io_out_next;
  logic              io_oe_reg, io_oe_next;
  logic              mem_req_reg, mem_req_next;
  logic [ADDR_W-3:0] mem_addr_reg, mem_addr_next;
  logic              req_d_reg;
  logic [31:0]       word_reg;

  logic [7:0]        cmd_shift;
  logic [ADDR_W-1:0] addr_shift;
  logic [ADDR_W-1:0] addr_inc;
  logic [CNT_W-1:0]  addr_last;
  logic [7:0]        cur_byte;

`ifdef QSPI_RESP_QUAD_IO_EN
  logic quad_reg, quad_next;
  assign addr_shift = quad_reg ? {addr_reg[ADDR_W-5:0], io_s}
                               : {addr_reg[ADDR_W-2:0], io_s[0]};
  assign addr_last  = quad_reg ? CNT_W'(ADDR_W/4 - 1) : CNT_W'(ADDR_W - 1);
`else
  logic unused_io;
  assign unused_io  = ^io_s[3:1];
  assign addr_shift = {addr_reg[ADDR_W-2:0], io_s[0]};
  assign addr_last  = CNT_W'(ADDR_W - 1);
`endif

  assign cmd_shift = {cmd_reg, io_s[0]};
  assign addr_inc  = addr_reg + ADDR_W'(1);
  assign cur_byte  = word_reg[{addr_reg[1:0], 3'b000} +: 8];

  always_comb begin
    state_next    = state_reg;
    cmd_next      = cmd_reg;
    addr_next     = addr_reg;
    cnt_next      = cnt_reg;
    nib_lo_next   = nib_lo_reg;
    io_out_next   = io_out_reg;
    io_oe_next    = io_oe_reg;
    mem_req_next  = 1'b0;
    mem_addr_next = mem_addr_reg;
`ifdef QSPI_RESP_QUAD_IO_EN
    quad_next     = quad_reg;
`endif
    if (state_reg != ST_IDLE && csb_level) begin
      state_next = ST_IDLE;
      io_oe_next = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (csb_fall) begin
            state_next = ST_CMD;
            cnt_next   = '0;
          end
        end
        ST_CMD: begin
          if (sclk_rise) begin
            cmd_next = cmd_shift[6:0];
            cnt_next = cnt_reg + 1'b1;
            if (cnt_reg == CNT_W'(7)) begin
              cnt_next = '0;
              if (cmd_shift == QSPI_OP_READ_QUAD_OUT) begin
                state_next = ST_ADDR;
`ifdef QSPI_RESP_QUAD_IO_EN
                quad_next  = 1'b0;
              end else if (cmd_shift == QSPI_OP_READ_QUAD_IO) begin
                state_next = ST_ADDR;
                quad_next  = 1'b1;
`endif
              end else begin
                state_next = ST_IGNORE;
              end
            end
          end
        end
        ST_ADDR: begin
          if (sclk_rise) begin
            addr_next = addr_shift;
            cnt_next  = cnt_reg + 1'b1;
            if (cnt_reg == addr_last) begin
              mem_req_next  = 1'b1;
              mem_addr_next = addr_shift[ADDR_W-1:2];
              cnt_next      = '0;
              state_next    = ST_DUMMY;
            end
          end
        end
        // Quad I/O's two mode-byte cycles plus its shortened dummy run equal the full count.
        ST_DUMMY: begin
          if (sclk_rise) begin
            cnt_next = cnt_reg + 1'b1;
            if (cnt_reg == CNT_W'(DUMMY_CYCLES - 1)) begin
              state_next  = ST_DATA;
              nib_lo_next = 1'b0;
            end
          end
        end
        ST_DATA: begin
          if (sclk_fall) begin
            io_oe_next = 1'b1;
            if (!nib_lo_reg) begin
              io_out_next = cur_byte[7:4];
              nib_lo_next = 1'b1;
            end else begin
              io_out_next = cur_byte[3:0];
              nib_lo_next = 1'b0;
              addr_next   = addr_inc;
              if (addr_inc[1:0] == 2'b00) begin
                mem_req_next  = 1'b1;
                mem_addr_next = addr_inc[ADDR_W-1:2];
              end
            end
          end
        end
        ST_IGNORE: io_oe_next = 1'b0;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      cmd_reg      <= '0;
      addr_reg     <= '0;
      cnt_reg      <= '0;
      nib_lo_reg   <= 1'b0;
      io_out_reg   <= '0;
      io_oe_reg    <= 1'b0;
      mem_req_reg  <= 1'b0;
      mem_addr_reg <= '0;
      req_d_reg    <= 1'b0;
      word_reg     <= '0;
`ifdef QSPI_RESP_QUAD_IO_EN
      quad_reg     <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      cmd_reg      <= cmd_next;
      addr_reg     <= addr_next;
      cnt_reg      <= cnt_next;
      nib_lo_reg   <= nib_lo_next;
      io_out_reg   <= io_out_next;
      io_oe_reg    <= io_oe_next;
      mem_req_reg  <= mem_req_next;
      mem_addr_reg <= mem_addr_next;
      req_d_reg    <= mem_req_reg;
      if (req_d_reg) word_reg <= mem_rdata;
`ifdef QSPI_RESP_QUAD_IO_EN
      quad_reg     <= quad_next;
`endif
    end
  end

  assign io_out   = io_out_reg;
  assign io_oe    = io_oe_reg;
  assign mem_req  = mem_req_reg;
  assign mem_addr = mem_addr_reg;
  assign busy     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Self-checking bench for qspi_flash_responder: table vectors, random reads, reset/abort corners.
module tb_qspi_flash_responder;
  import qspi_pkg::*;

  localparam int ADDR_W = 24;
  localparam int DUMMY  = 8;
  localparam int H      = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sclk = 1'b0;
  logic              csb = 1'b1;
  logic [3:0]        io_in = 4'h0;
  logic [3:0]        io_out;
  logic              io_oe;
  logic              mem_req;
  logic [ADDR_W-3:0] mem_addr;
  logic [31:0]       mem_rdata = 32'h0;
  logic              busy;

  int total = 0;
  int bad = 0;

  qspi_flash_responder #(.ADDR_W(ADDR_W), .DUMMY_CYCLES(DUMMY)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .csb(csb), .io_in(io_in),
    .io_out(io_out), .io_oe(io_oe), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [21:0] wa);
    if (wa == 22'd0) return 32'hDDCCBBAA;
    return (32'(wa) * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction

  function automatic logic [7:0] ref_byte(input logic [23:0] a);
    logic [31:0] w;
    w = mem_word(a[23:2]);
    return 8'((w >> (8 * int'(a % 4))) & 32'hFF);
  endfunction

  always @(posedge clk) if (mem_req) mem_rdata <= mem_word(mem_addr);

  int               req_cnt = 0;
  logic [21:0]      req_addr_q[$];
  logic             prev_req = 1'b0;
  bit               oe_seen = 1'b0;

  always @(negedge clk) begin
    if (mem_req) begin
      total++;
      if (prev_req) begin
        bad++;
        $display("FAIL mem_req_gap: got back-to-back mem_req, required isolated pulse");
      end
      req_cnt++;
      req_addr_q.push_back(mem_addr);
    end
    prev_req = mem_req;
    if (io_oe) oe_seen = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic sclk_cycle(input logic [3:0] d, output logic [3:0] q);
    io_in = d;
    repeat (H) @(negedge clk);
    q = io_out;
    sclk = 1'b1;
    repeat (H) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] op);
    logic [3:0] q;
    csb = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 7; i >= 0; i--) sclk_cycle({3'b000, op[i]}, q);
  endtask

  task automatic run_check(input logic [7:0] op, input logic [23:0] a, input int nbytes,
                           input int exp_nreq_in);
    bit          accept;
    bit          quad;
    logic [3:0]  q;
    logic [3:0]  nibs[$];
    logic [21:0] exp_q[$];
    logic [23:0] na;
    int          exp_nreq;
    accept = (op == QSPI_OP_READ_QUAD_OUT);
    quad   = 1'b0;
`ifdef QSPI_RESP_QUAD_IO_EN
    if (op == QSPI_OP_READ_QUAD_IO) begin
      accept = 1'b1;
      quad   = 1'b1;
    end
`endif
    if (accept) begin
      exp_q.push_back(a[23:2]);
      for (int i = 1; i <= nbytes; i++) begin
        na = a + 24'(i);
        if (na % 4 == 0) exp_q.push_back(na[23:2]);
      end
    end
    exp_nreq = (exp_nreq_in < 0) ? exp_q.size() : exp_nreq_in;
    req_cnt = 0;
    req_addr_q.delete();
    oe_seen = 1'b0;
    send_cmd(op);
    if (quad) begin
      for (int i = 5; i >= 0; i--) sclk_cycle(a[4*i +: 4], q);
    end else begin
      for (int i = 23; i >= 0; i--) sclk_cycle({3'b000, a[i]}, q);
    end
    for (int i = 0; i < DUMMY; i++) sclk_cycle(4'h0, q);
    for (int i = 0; i < 2 * nbytes; i++) begin
      sclk_cycle(4'h0, q);
      nibs.push_back(q);
    end
    csb = 1'b1;
    repeat (3) @(negedge clk);
    check("busy_after_csb", 32'(busy), 32'd0);
    check("io_oe_seen", 32'(oe_seen), 32'(accept));
    check("mem_req_count", 32'(req_cnt), 32'(exp_nreq));
    if (accept) begin
      for (int i = 0; i < nbytes; i++)
        check("data_byte", {24'h0, nibs[2*i], nibs[2*i+1]}, 32'(ref_byte(a + 24'(i))));
      for (int i = 0; i < exp_q.size() && i < req_addr_q.size(); i++)
        check("mem_addr", 32'(req_addr_q[i]), 32'(exp_q[i]));
    end
    $display("txn op=%02h addr=%06h bytes=%0d reqs=%0d oe=%0b", op, a, nbytes, req_cnt, oe_seen);
    repeat (4) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [23:0] addr;
    int          nbytes;
    int          exp_nreq;
  } vec_t;

  initial begin
    vec_t        vecs[$];
    logic [3:0]  q;
    logic [7:0]  rop;
    logic [23:0] raddr;

    vecs.push_back('{8'h6B, 24'h000000, 4, 2});
    vecs.push_back('{8'h6B, 24'h000003, 2, 2});
    vecs.push_back('{8'h03, 24'h000000, 2, 0});
    vecs.push_back('{8'h6B, 24'hFFFFFF, 2, 2});
`ifdef QSPI_RESP_QUAD_IO_EN
    vecs.push_back('{8'hEB, 24'h000004, 4, 2});
`else
    vecs.push_back('{8'hEB, 24'h000004, 2, 0});
`endif

    repeat (4) @(negedge clk);
    check("rst_io_oe", 32'(io_oe), 32'd0);
    check("rst_io_out", 32'(io_out), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Abort after 12 address bits: nothing fetched, next read still correct.
    req_cnt = 0;
    send_cmd(8'h6B);
    for (int i = 0; i < 12; i++) sclk_cycle(4'h1, q);
    csb = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (4) @(negedge clk);
    check("abort_mem_req", 32'(req_cnt), 32'd0);
    $display("txn abort after 12 address bits reqs=%0d", req_cnt);
    run_check(8'h6B, 24'h000010, 3, 1);

    foreach (vecs[k]) run_check(vecs[k].op, vecs[k].addr, vecs[k].nbytes, vecs[k].exp_nreq);

    // Reset pulsed in the middle of the data phase.
    oe_seen = 1'b0;
    send_cmd(8'h6B);
    for (int i = 0; i < 24 + DUMMY + 2; i++) sclk_cycle(4'h0, q);
    check("pre_rst_io_oe", 32'(io_oe), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_io_oe", 32'(io_oe), 32'd0);
    check("mid_rst_io_out", 32'(io_out), 32'd0);
    check("mid_rst_mem_req", 32'(mem_req), 32'd0);
    check("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    oe_seen = 1'b0;
    req_cnt = 0;
    for (int i = 0; i < 6; i++) sclk_cycle(4'h0, q);
    check("post_rst_quiet_oe", 32'(oe_seen), 32'd0);
    check("post_rst_quiet_busy", 32'(busy), 32'd0);
    check("post_rst_quiet_req", 32'(req_cnt), 32'd0);
    csb = 1'b1;
    repeat (6) @(negedge clk);
    $display("txn reset during data phase");

    for (int n = 0; n < 8; n++) begin
      rop = 8'h6B;
      if ($urandom_range(0, 3) == 0) begin
        rop = 8'($urandom());
        if (rop == 8'h6B || rop == 8'hEB) rop = 8'h0B;
      end
      raddr = 24'($urandom());
      if ($urandom_range(0, 3) == 0) raddr = 24'hFFFFFC + 24'($urandom_range(0, 3));
      run_check(rop, raddr, int'($urandom_range(1, 6)), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
